// File: rtl/ret_addr_stack_if.sv
// Interface between next-PC logic and the return-address stack.
// The master side issues call/ret operations; the slave side is the stack itself.
interface ret_addr_stack_if #(
  parameter int unsigned CNT_W = 4
);
  logic             push;
  logic             pop;
  logic [15:0]      push_addr;
  logic             stall;
  logic             err_clr;
  logic [15:0]      ret_addr;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             ovf_err;
  logic             unf_err;

  modport master (
    output push, pop, push_addr, stall, err_clr,
    input  ret_addr, empty, full, count, ovf_err, unf_err
  );

  modport slave (
    input  push, pop, push_addr, stall, err_clr,
    output ret_addr, empty, full, count, ovf_err, unf_err
  );
endinterface

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: calls push the return PC, rets pop it.
// Overflow overwrites the oldest entry; over/underflow raise sticky error flags.
module ret_addr_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = PTR_W + 1
) (
  input logic               clk,
  input logic               rst,
  ret_addr_stack_if.slave   bus
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] top_q, top_d, top_m1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             is_empty, is_full;
  logic             we;
  logic [PTR_W-1:0] waddr;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCnt);
  assign top_m1   = top_q - PTR_W'(1);

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = top_q;
    if (!bus.stall) begin
      // Clear first so an error raised this cycle wins over err_clr.
      if (bus.err_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (bus.push && bus.pop && !is_empty) begin
        we    = 1'b1;
        waddr = top_m1;
      end else if (bus.push) begin
        we    = 1'b1;
        top_d = top_q + PTR_W'(1);
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
        if (bus.pop) begin
          unf_d = 1'b1;
        end
      end else if (bus.pop) begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          top_d   = top_m1;
          count_d = count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not cleared on reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= bus.push_addr;
    end
  end

  assign bus.ret_addr = is_empty ? 16'h0000 : mem[top_m1];
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.ovf_err  = ovf_q;
  assign bus.unf_err  = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: a queue-based stack model feeds a
// scoreboard of expected post-edge state, compared on the following falling edge.
module tb_ret_addr_stack;

  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst;

  ret_addr_stack_if #(.CNT_W(4)) bus ();

  ret_addr_stack #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ra;
    logic [3:0]  cnt;
    logic        e;
    logic        f;
    logic        o;
    logic        u;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] m_stk [$];
  logic        m_ovf;
  logic        m_unf;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [15:0] m_top();
    if (m_stk.size() == 0) return 16'h0000;
    return m_stk[m_stk.size()-1];
  endfunction

  // One clock: drive inputs, update model, push expectation, compare after the edge.
  task automatic step(input logic p, input logic po, input logic [15:0] a,
                      input logic st, input logic clr, input logic r);
    exp_t e;
    bus.push      = p;
    bus.pop       = po;
    bus.push_addr = a;
    bus.stall     = st;
    bus.err_clr   = clr;
    rst           = r;
    #1;
    if (po && !st && !r) check("pop_cycle_ret", {16'h0, bus.ret_addr}, {16'h0, m_top()});
    if (r) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!st) begin
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (p && po && m_stk.size() > 0) begin
        m_stk[m_stk.size()-1] = a;
      end else if (p) begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_front());
          m_ovf = 1'b1;
        end
        m_stk.push_back(a);
        if (po) m_unf = 1'b1;
      end else if (po) begin
        if (m_stk.size() == 0) m_unf = 1'b1;
        else void'(m_stk.pop_back());
      end
    end
    e.ra  = m_top();
    e.cnt = 4'(m_stk.size());
    e.e   = (m_stk.size() == 0);
    e.f   = (m_stk.size() == DEPTH);
    e.o   = m_ovf;
    e.u   = m_unf;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("ret_addr", {16'h0, bus.ret_addr}, {16'h0, e.ra});
    check("count",    {28'h0, bus.count},    {28'h0, e.cnt});
    check("empty",    {31'h0, bus.empty},    {31'h0, e.e});
    check("full",     {31'h0, bus.full},     {31'h0, e.f});
    check("ovf_err",  {31'h0, bus.ovf_err},  {31'h0, e.o});
    check("unf_err",  {31'h0, bus.unf_err},  {31'h0, e.u});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;

    // Reset
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("rst_empty", {31'h0, bus.empty}, 32'h1);
    check("rst_ret",   {16'h0, bus.ret_addr}, 32'h0);

    // Basic LIFO
    step(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    check("t2_top", {16'h0, bus.ret_addr}, 32'h0030);
    check("t2_cnt", {28'h0, bus.count}, 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t2_empty", {31'h0, bus.empty}, 32'h1);

    // Overflow wrap
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
    check("t3_full", {31'h0, bus.full}, 32'h1);
    check("t3_ovf",  {31'h0, bus.ovf_err}, 32'h1);
    check("t3_top",  {16'h0, bus.ret_addr}, 32'h0109);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t3_empty", {31'h0, bus.empty}, 32'h1);

    // Underflow and err_clr
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t4_unf", {31'h0, bus.unf_err}, 32'h1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("t4_clr", {31'h0, bus.unf_err}, 32'h0);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);       // set beats clear
    step(1'b1, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);    // push+pop on empty
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);

    // Replace top
    step(1'b1, 1'b0, 16'h0999, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0AAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0BBB, 1'b0, 1'b0, 1'b0);
    check("t5_top", {16'h0, bus.ret_addr}, 32'h0BBB);
    check("t5_cnt", {28'h0, bus.count}, 32'd2);

    // Stall freezes everything, reset still wins
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0CCC, 1'b1, 1'b1, 1'b0);
    check("t6_stall_top", {16'h0, bus.ret_addr}, 32'h0BBB);
    step(1'b1, 1'b1, 16'h0DDD, 1'b1, 1'b0, 1'b1);
    check("t6_rst_empty", {31'h0, bus.empty}, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           16'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
